mux4_rr_arbiter: RTL

//  Round-robin arbiter sharing one 4:1 DATA_W-bit mux path between four requesters.
//  - Registers the owner and drives the mux select; the mux is built from 1-bit 4:1 mux cells.
//  - Ownership is held until the owner releases it; the winner's data goes to one output port.
//  - Sits in front of shared resources such as a debug/CSR read-back bus or a shared memory port.

---
 rtl/mux4_rr_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux4_rr_arbiter (with helper cell mux4_bit)
//  Purpose  : Round-robin arbiter that shares one 4:1 DATA_W-bit mux path
//             between four requesters. The owner is registered and drives the
//             mux select. Ownership is held until the owner drops its request
//             or strobes i_last. The released owner becomes lowest priority.
//  Ports    : i_clk, i_rst_n (async active-low)
//             i_req[3:0]  level requests       i_last[3:0] owner release strobe
//             i_data0..3  requester data words
//             o_gnt[3:0]  one-hot grant        o_sel[1:0]  owner index
//             o_valid     grant held           o_data      i_data[o_sel]
//             o_timeout   forced-release pulse
//  Options  : MUX4_ARB_TIMEOUT_EN - when defined, ownership is force-released
//             after MAX_HOLD consecutive owned cycles. When it is not defined,
//             o_timeout is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================

// One bit of the shared data path: a plain 4:1 selector.
module mux4_bit (
    input  logic [3:0] i_d,
    input  logic [1:0] i_sel,
    output logic       o_y
);
    assign o_y = i_d[i_sel];
endmodule

module mux4_rr_arbiter #(
    parameter int DATA_W   = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [3:0]        i_req,
    input  logic [3:0]        i_last,
    input  logic [DATA_W-1:0] i_data0,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
    input  logic [DATA_W-1:0] i_data3,
    output logic [3:0]        o_gnt,
    output logic [1:0]        o_sel,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_timeout
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_ptr,   w_ptr_nxt;
    logic [1:0] r_sel,   w_sel_nxt;
    logic [3:0] r_gnt,   w_gnt_nxt;
    logic       r_valid, w_valid_nxt;
    logic       w_grant_new;

    // Arbitration inputs: candidate set and the index scanning starts from.
    logic [3:0] w_cand;
    logic [1:0] w_base;
    logic [1:0] w_win;
    logic       w_win_any;

    logic       w_rel_natural;
    logic       w_forced;
    logic       w_release;

    // Owner lets go when it drops its request or strobes its own i_last.
    assign w_rel_natural = (r_state == ST_OWN) && (!i_req[r_sel] || i_last[r_sel]);
    assign w_release     = w_rel_natural || w_forced;

    // While owning, the owner is masked out and scanning starts just above it,
    // so the outgoing owner can never win the re-arbitration on its release edge.
    always_comb begin
        if (r_state == ST_OWN) begin
            w_cand = i_req & ~r_gnt;
            w_base = r_sel + 2'd1;
        end else begin
            w_cand = i_req;
            w_base = r_ptr;
        end
    end

    // First set candidate scanning upward (mod 4) from w_base.
    always_comb begin
        logic [1:0] v_idx;
        w_win     = 2'd0;
        w_win_any = 1'b0;
        v_idx     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            v_idx = w_base + 2'(i);
            if (!w_win_any && w_cand[v_idx]) begin
                w_win     = v_idx;
                w_win_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_gnt_nxt   = r_gnt;
        w_valid_nxt = r_valid;
        w_grant_new = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_win_any) begin
                    w_state_nxt = ST_OWN;
                    w_sel_nxt   = w_win;
                    w_gnt_nxt   = 4'b0001 << w_win;
                    w_valid_nxt = 1'b1;
                    w_grant_new = 1'b1;
                end
            end
            ST_OWN: begin
                if (w_release) begin
                    w_ptr_nxt = r_sel + 2'd1;
                    if (w_win_any) begin
                        // Hand-over without an idle bubble.
                        w_sel_nxt   = w_win;
                        w_gnt_nxt   = 4'b0001 << w_win;
                        w_grant_new = 1'b1;
                    end else begin
                        // o_sel intentionally keeps the last owner.
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = 4'b0000;
                        w_valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 4'b0000;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_sel   <= 2'd0;
            r_gnt   <= 4'b0000;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
            r_valid <= w_valid_nxt;
        end
    end

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam int              c_hold_w   = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(MAX_HOLD - 1);

    logic [c_hold_w-1:0] r_hold;
    logic                r_timeout;

    // Counter reads 0 on the first owned cycle, so reaching MAX_HOLD-1 means
    // MAX_HOLD owned cycles have elapsed. A natural release at that point
    // takes precedence and does not raise o_timeout.
    assign w_forced = (r_state == ST_OWN) && (r_hold == c_hold_max) && !w_rel_natural;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_forced;
            if (w_grant_new) begin
                r_hold <= '0;
            end else if (r_state == ST_OWN) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    logic w_unused_cfg;

    assign w_forced     = 1'b0;
    assign o_timeout    = 1'b0;
    assign w_unused_cfg = (MAX_HOLD >= 2) ^ w_grant_new;
`endif

    // Shared data path, built bit by bit from 4:1 mux cells.
    for (genvar b = 0; b < DATA_W; b++) begin : g_mux
        mux4_bit u_bit (
            .i_d   ({i_data3[b], i_data2[b], i_data1[b], i_data0[b]}),
            .i_sel (r_sel),
            .o_y   (o_data[b])
        );
    end

    assign o_gnt   = r_gnt;
    assign o_sel   = r_sel;
    assign o_valid = r_valid;

endmodule
`default_nettype wire
